// File: rtl/tlv5618_pkg.sv
// rtl/tlv5618_pkg.sv - shared FSM encoding and TLV5618 control-word fields
package tlv5618_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEND_B = 3'd1,
    S_WAIT_B = 3'd2,
    S_GAP    = 3'd3,
    S_SEND_A = 3'd4,
    S_WAIT_A = 3'd5
  } state_t;

  localparam int R1_BIT  = 15;
  localparam int SPD_BIT = 14;
  localparam int PWR_BIT = 13;
  localparam int R0_BIT  = 12;

  localparam logic [1:0] RR_BUF      = 2'b01;
  localparam logic [1:0] RR_A_UPD    = 2'b10;
  localparam logic [1:0] RR_B_DIRECT = 2'b00;

  // Power-down is never requested, so PWR is always cleared.
  function automatic logic [15:0] cmd_word(input logic [1:0] r1r0, input logic spd,
                                           input logic [11:0] code);
    logic [15:0] word;
    word          = {4'b0000, code};
    word[R1_BIT]  = r1r0[1];
    word[SPD_BIT] = spd;
    word[PWR_BIT] = 1'b0;
    word[R0_BIT]  = r1r0[0];
    return word;
  endfunction

endpackage

// File: rtl/tlv5618_tick_gen.sv
// rtl/tlv5618_tick_gen.sv - update-rate divider; counter parks at 0 while disabled
module tlv5618_tick_gen #(
  parameter int TICK_DIV = 499
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;

  logic [W-1:0] cnt;
  logic         at_end;

  assign at_end = (cnt == W'(TICK_DIV));
  assign tick   = enable && at_end;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt <= '0;
    end else if (at_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/tlv5618_frame_ctrl.sv
// rtl/tlv5618_frame_ctrl.sv - two-transfer frame sequencer for the TLV5618 driver
// Optional set_done watchdog and sticky timeout_err: TLV5618_FRAME_CTRL_TIMEOUT_EN
module tlv5618_frame_ctrl
  import tlv5618_pkg::*;
#(
  parameter int   CLOCK_FREQ  = 50_000_000,
  parameter int   UPDATE_FREQ = 100_000,
  parameter int   TICK_DIV    = CLOCK_FREQ / UPDATE_FREQ - 1,
  parameter int   GAP_CYC     = 4,
  parameter logic SPD_FAST    = 1'b1
`ifdef TLV5618_FRAME_CTRL_TIMEOUT_EN
  ,
  parameter int   TIMEOUT_CYC = 1023
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [11:0] sample_a,
  input  logic [11:0] sample_b,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic [15:0] set_data,
  output logic        set_go,
  input  logic        set_done,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun,
  output logic        overrun
`ifdef TLV5618_FRAME_CTRL_TIMEOUT_EN
  ,
  output logic        timeout_err
`endif
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_t          state, state_next;
  logic            tick;
  logic            hold_full;
  logic [11:0]     hold_a, hold_b, work_a;
  logic [GW-1:0]   gap_cnt;
  logic            gap_last, accept, start, timeout;

  tlv5618_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  assign sample_ready = ~hold_full;
  assign accept       = sample_valid && !hold_full;
  assign start        = (state == S_IDLE) && tick && hold_full;
  assign gap_last     = (gap_cnt == GW'(GAP_CYC - 1));

`ifdef TLV5618_FRAME_CTRL_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wd_cnt;
  logic          in_wait;

  assign in_wait = (state == S_WAIT_B) || (state == S_WAIT_A);
  assign timeout = in_wait && !set_done && (wd_cnt == WW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_cnt      <= in_wait ? wd_cnt + WW'(1) : '0;
      timeout_err <= timeout_err | timeout;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start)    state_next = S_SEND_B;
      S_SEND_B:               state_next = S_WAIT_B;
      S_WAIT_B: if (set_done) state_next = S_GAP;
      S_GAP:    if (gap_last) state_next = S_SEND_A;
      S_SEND_A:               state_next = S_WAIT_A;
      S_WAIT_A: if (set_done) state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
    if (timeout) state_next = S_IDLE;
  end

  always_comb begin
    busy   = (state != S_IDLE);
    set_go = (state == S_SEND_B) || (state == S_SEND_A);
  end

  // set_data is loaded on the edge that enters a SEND state, so it is valid with set_go.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full  <= 1'b0;
      hold_a     <= '0;
      hold_b     <= '0;
      work_a     <= '0;
      set_data   <= '0;
      gap_cnt    <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= (state == S_WAIT_A) && set_done;
      underrun   <= tick && (state == S_IDLE) && !hold_full;
      overrun    <= tick && (state != S_IDLE);
      gap_cnt    <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;
      if (start) begin
        hold_full <= 1'b0;
        work_a    <= hold_a;
        set_data  <= cmd_word(RR_BUF, SPD_FAST, hold_b);
      end else if (accept) begin
        hold_full <= 1'b1;
        hold_a    <= sample_a;
        hold_b    <= sample_b;
      end
      if ((state == S_GAP) && gap_last) begin
        set_data <= cmd_word(RR_A_UPD, SPD_FAST, work_a);
      end
    end
  end

endmodule
